// File: rtl/div_unit_seq_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM encodings.
// The state constants are plain localparams so older datapath code can compare against them.
package div_unit_seq_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/div_unit_seq_if.sv
// Request/result bundle between ControlUnit (master) and the divider (slave).
interface div_unit_seq_if
   import div_unit_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_zero, div_hi, div_lo
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_zero, div_hi, div_lo
   );

endinterface

// File: rtl/div_unit_seq_step.sv
// One restoring-division iteration on unsigned magnitudes, purely combinational.
module div_restoring_step
   import div_unit_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-2:0] remLow,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divMag,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] quoNext
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   trial;

   // The partial remainder stays below divMag <= 2^(WIDTH-1), so its MSB is always
   // zero and the shifted value fits in WIDTH bits; bit WIDTH of trial is the borrow.
   assign shifted = {remLow, quo[WIDTH-1]};
   assign trial   = {1'b0, shifted} - {1'b0, divMag};
   assign remNext = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
   assign quoNext = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit_seq.sv
// Multicycle MIPS DIV: one restoring step per clock on magnitudes, signs fixed up at the end.
module div_unit_seq
   import div_unit_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic         clk,
   input logic         reset,
   div_unit_seq_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divMag;
   logic             signQ;
   logic             signR;
   logic             doneQ;
   logic             divZeroQ;
   logic [WIDTH-1:0] divHiQ;
   logic [WIDTH-1:0] divLoQ;

   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;

   // Two's-complement negate of INT_MIN yields 2^(WIDTH-1), the exact unsigned magnitude.
   assign dividendMag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign divisorMag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

   div_restoring_step #(.WIDTH(WIDTH)) uStep (
      .remLow  (rem[WIDTH-2:0]),
      .quo     (quo),
      .divMag  (divMag),
      .remNext (remNext),
      .quoNext (quoNext)
   );

   // NOTE: every register, datapath included, is cleared by reset so an aborted
   // divide leaves no stale operands or result behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         divMag   <= '0;
         signQ    <= 1'b0;
         signR    <= 1'b0;
         doneQ    <= 1'b0;
         divZeroQ <= 1'b0;
         divHiQ   <= '0;
         divLoQ   <= '0;
      end else begin
         doneQ <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.divisor == '0) begin
                     doneQ    <= 1'b1;
                     divZeroQ <= 1'b1;
                  end else begin
                     divZeroQ <= 1'b0;
                     signQ    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                     signR    <= bus.dividend[WIDTH-1];
                     quo      <= dividendMag;
                     divMag   <= divisorMag;
                     rem      <= '0;
                     cnt      <= CNT_W'(WIDTH - 1);
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= remNext;
               quo <= quoNext;
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - CNT_W'(1);
            end
            FIX: begin
               divLoQ <= signQ ? -quo : quo;
               divHiQ <= signR ? -rem : rem;
               doneQ  <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = doneQ;
   assign bus.div_zero = divZeroQ;
   assign bus.div_hi   = divHiQ;
   assign bus.div_lo   = divLoQ;

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed and randomized checks of div_unit_seq against a 64-bit arithmetic reference.
module tb_div_unit_seq;
   import div_unit_seq_pkg::*;

   localparam int W   = DIV_WIDTH;
   localparam int LAT = W + 1;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   nChecks = 0;
   int   nErrors = 0;
   logic [W-1:0] expHi = '0;
   logic [W-1:0] expLo = '0;
   int   n;
   int   doneSeen;

   div_unit_seq_if #(.WIDTH(W)) bus ();

   div_unit_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (rstN),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: signed division in 64 bits truncates toward zero, remainder takes the
   // dividend's sign; truncating back to W bits gives the wrap of INT_MIN / -1.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
   endfunction

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < LAT + 8) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   // Issues one start pulse and checks the full response, including operand-change immunity.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int c;
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom();
      bus.divisor  = $urandom();
      if (b == '0) begin
         check({tag, "_zdone"}, W'(bus.done), W'(1));
         check({tag, "_zflag"}, W'(bus.div_zero), W'(1));
         check({tag, "_zbusy"}, W'(bus.busy), W'(0));
         check({tag, "_zhi"}, bus.div_hi, expHi);
         check({tag, "_zlo"}, bus.div_lo, expLo);
      end else begin
         model(a, b, expLo, expHi);
         check({tag, "_busy"}, W'(bus.busy), W'(1));
         check({tag, "_zclr"}, W'(bus.div_zero), W'(0));
         waitDone(c);
         check({tag, "_lat"}, W'(c), W'(LAT));
         check({tag, "_lo"}, bus.div_lo, expLo);
         check({tag, "_hi"}, bus.div_hi, expHi);
      end
      @(posedge clk); #1;
      check({tag, "_pulse"}, W'(bus.done), W'(0));
      check({tag, "_idle"}, W'(bus.busy), W'(0));
      check({tag, "_zhold"}, W'(bus.div_zero), W'(b == '0));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset state
      #12;
      check("rst_busy", W'(bus.busy), W'(0));
      check("rst_done", W'(bus.done), W'(0));
      check("rst_zero", W'(bus.div_zero), W'(0));
      check("rst_hi", bus.div_hi, '0);
      check("rst_lo", bus.div_lo, '0);
      @(negedge clk);
      rstN = 1'b1;

      // Basic signs
      runOp(32'd100, 32'd7, "p_by_p");
      check("t1_lo", bus.div_lo, 32'd14);
      check("t1_hi", bus.div_hi, 32'd2);
      runOp(-32'sd100, 32'd7, "n_by_p");
      check("t2_lo", bus.div_lo, 32'hFFFF_FFF2);
      check("t2_hi", bus.div_hi, 32'hFFFF_FFFE);
      runOp(32'd100, -32'sd7, "p_by_n");
      check("t2b_lo", bus.div_lo, 32'hFFFF_FFF2);
      check("t2b_hi", bus.div_hi, 32'd2);

      // Divide by zero keeps the previous result, next valid start clears the flag
      runOp(32'd9, 32'd4, "preload");
      runOp(32'd5, 32'd0, "div0");
      check("t3_hi", bus.div_hi, 32'd1);
      check("t3_lo", bus.div_lo, 32'd2);
      runOp(32'd21, 32'd5, "after0");

      // Overflow and INT_MIN boundaries
      runOp(32'h8000_0000, 32'hFFFF_FFFF, "ovf");
      check("t4_lo", bus.div_lo, 32'h8000_0000);
      check("t4_hi", bus.div_hi, 32'd0);
      runOp(32'h8000_0000, 32'd1, "min_by1");
      check("t4b_lo", bus.div_lo, 32'h8000_0000);
      runOp(32'd7, 32'h8000_0000, "by_min");
      runOp(-32'sd12, 32'd4, "negexact");

      // Start while busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      bus.dividend = 32'd8;
      bus.divisor  = 32'd2;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("t5_busy", W'(bus.busy), W'(1));
      waitDone(n);
      check("t5_lat", W'(n + 5), W'(LAT));
      check("t5_lo", bus.div_lo, 32'd333);
      check("t5_hi", bus.div_hi, 32'd1);
      bus.dividend = 32'd6;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b_busy", W'(bus.busy), W'(1));
      check("b2b_pulse", W'(bus.done), W'(0));
      waitDone(n);
      check("b2b_lat", W'(n), W'(LAT));
      check("b2b_lo", bus.div_lo, 32'd2);
      check("b2b_hi", bus.div_hi, 32'd0);

      // Asynchronous reset aborts an operation in flight
      @(negedge clk);
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
      end
      #2;
      rstN = 1'b0;
      #1;
      check("t6_busy", W'(bus.busy), W'(0));
      check("t6_done", W'(bus.done), W'(0));
      check("t6_zero", W'(bus.div_zero), W'(0));
      check("t6_hi", bus.div_hi, '0);
      check("t6_lo", bus.div_lo, '0);
      expHi = '0;
      expLo = '0;
      @(negedge clk);
      rstN = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < LAT + 5; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) doneSeen++;
      end
      check("t6_nodone", W'(doneSeen), W'(0));
      runOp(32'd6, 32'd3, "t6_next");
      check("t6_lo2", bus.div_lo, 32'd2);
      check("t6_hi2", bus.div_hi, 32'd0);

      // Randomized operands, with occasional zero and small divisors
      for (int i = 0; i < 20; i++) begin
         ra = $urandom();
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = W'($signed(6'($urandom())));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom();
         endcase
         if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
         runOp(ra, rb, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
